// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: writeback select, load types and the $zero register.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } load_type_e;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/load_formatter.sv
// Big-endian load extraction and extension from an aligned memory word.
// Purely combinational so it can be shared with the cache refill path.
module load_formatter
    import mips_pkg::*;
(
    input  logic [2:0]        loadType,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte 0 is the most significant byte of the word.
    always_comb begin
        w_byte = memData[31:24];
        case (offset)
            2'd0: w_byte = memData[31:24];
            2'd1: w_byte = memData[23:16];
            2'd2: w_byte = memData[15:8];
            2'd3: w_byte = memData[7:0];
            default: w_byte = memData[31:24];
        endcase
        w_half = offset[1] ? memData[15:0] : memData[31:16];
    end

    always_comb begin
        data     = memData;
        misalign = 1'b0;
        case (loadType)
            LD_B:  data = {{24{w_byte[7]}}, w_byte};
            LD_BU: data = {24'd0, w_byte};
            LD_H: begin
                data     = {{16{w_half[15]}}, w_half};
                misalign = offset[0];
            end
            LD_HU: begin
                data     = {16'd0, w_half};
                misalign = offset[0];
            end
            default: begin
                data     = memData;
                misalign = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter; drives the register file
// write port, the EX forwarding bus and a retired-instruction counter.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic              inRegWrite,
    input  logic [1:0]        inWbSel,
    input  logic [2:0]        inLoadType,
    input  logic [REG_W-1:0]  inDestReg,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inMemData,
    input  logic [DATA_W-1:0] inPc,
    output logic              wrEnable,
    output logic [REG_W-1:0]  wrReg,
    output logic [DATA_W-1:0] wrData,
    output logic              fwdValid,
    output logic [REG_W-1:0]  fwdReg,
    output logic [DATA_W-1:0] fwdData,
    output logic              misalignErr,
    output logic [31:0]       retireCount
);

    logic              r_valid;
    logic              r_regWrite;
    logic [1:0]        r_wbSel;
    logic [2:0]        r_loadType;
    logic [REG_W-1:0]  r_destReg;
    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_memData;
    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_retireCount;

    logic [DATA_W-1:0] w_loadData;
    logic              w_loadMisalign;
    logic              w_misalignErr;
    logic [DATA_W-1:0] w_result;

    // Flush wins over stall; on flush only valid matters, the payload just holds.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_valid     <= 1'b0;
            r_regWrite  <= 1'b0;
            r_wbSel     <= '0;
            r_loadType  <= '0;
            r_destReg   <= '0;
            r_aluResult <= '0;
            r_memData   <= '0;
            r_pc        <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid     <= inValid;
            r_regWrite  <= inRegWrite;
            r_wbSel     <= inWbSel;
            r_loadType  <= inLoadType;
            r_destReg   <= inDestReg;
            r_aluResult <= inAluResult;
            r_memData   <= inMemData;
            r_pc        <= inPc;
        end
    end

    // An instruction retires on the edge that moves it out of the stage.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_retireCount <= '0;
        end else if (r_valid && !stall) begin
            r_retireCount <= r_retireCount + 32'd1;
        end
    end

    load_formatter u_load_formatter (
        .loadType (r_loadType),
        .offset   (r_aluResult[1:0]),
        .memData  (r_memData),
        .data     (w_loadData),
        .misalign (w_loadMisalign)
    );

    always_comb begin
        case (r_wbSel)
            WB_LOAD: w_result = w_loadData;
            WB_LINK: w_result = r_pc + 32'd8;
            default: w_result = r_aluResult;
        endcase
        w_misalignErr = r_valid && (r_wbSel == WB_LOAD) && w_loadMisalign;
    end

    assign misalignErr = w_misalignErr;
    assign wrEnable    = r_valid && r_regWrite && (r_destReg != REG_ZERO) && !w_misalignErr;
    assign wrReg       = r_destReg;
    assign wrData      = w_result;
    assign fwdValid    = wrEnable;
    assign fwdReg      = wrReg;
    assign fwdData     = wrData;
    assign retireCount = r_retireCount;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback formatter for the pipelined MIPS core. It captures the memory-stage result on each rising edge and selects ALU result, formatted load data or link address. It drives the register file write port (wrEnable/wrReg/wrData) and the EX-stage forwarding bus. It also keeps a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- REG_W, 5, register address width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rstN  in  1  reset, asynchronous and active-low.
- stall  in  1  hold all stage registers.
- flush  in  1  insert bubble: captured valid is cleared.
- inValid  in  1  MEM stage holds a real instruction.
- inRegWrite  in  1  instruction writes a register.
- inWbSel  in  2  result select: 00 ALU, 01 load, 10 link (PC+8), 11 reserved (treated as 00).
- inLoadType  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW.
- inDestReg  in  REG_W  destination register.
- inAluResult  in  DATA_W  ALU result; bits [1:0] are the load byte offset.
- inMemData  in  DATA_W  raw aligned word read from data memory.
- inPc  in  DATA_W  instruction PC.
- wrEnable  out  1  register file write enable.
- wrReg  out  REG_W  register file write address.
- wrData  out  DATA_W  register file write data.
- fwdValid  out  1  forwarding bus valid; equals wrEnable.
- fwdReg  out  REG_W  equals wrReg.
- fwdData  out  DATA_W  equals wrData.
- misalignErr  out  1  registered instruction is a misaligned load.
- retireCount  out  32  count of valid instructions retired.

## Operation
- Stage registers are valid, regWrite, wbSel, loadType, destReg, aluResult, memData and pc.
- Update priority on a rising edge: flush, then stall, then load.
  - flush: valid is cleared; other fields are don't-care.
  - stall: all registers hold.
  - otherwise: all in* values are captured.
- Load formatting is big-endian, with offset = aluResult[1:0].
  - LB/LBU: byte at memData[31-8*offset -: 8], sign- or zero-extended.
  - LH/LHU: halfword at memData[31:16] for offset 0, memData[15:0] for offset 2, sign- or zero-extended.
  - LW: memData unchanged.
- misalignErr = valid & (wbSel==01) & ((LW & offset!=0) | (LH/LHU & offset[0])).
- Link value is pc + 8, computed modulo 2^32 so it wraps.
- wrEnable = valid & regWrite & (destReg != 0) & ~misalignErr. Writes to $zero are never issued.
- wrReg = destReg and wrData = the selected value, even when wrEnable is 0.
- retireCount increments by 1 on each rising edge where valid is registered and the stage is not stalling. Misaligned loads count.
- retireCount wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: valid 0, all other stage registers 0.
  - Hence wrEnable, fwdValid and misalignErr are 0.
  - wrReg, fwdReg, wrData and fwdData are 0.
  - retireCount is 0.
- Latency is one cycle: inputs captured at edge N appear on the write port after edge N.
- The register file writes on the falling edge of the same cycle. Decode reads in the following half-cycle see the new value, so no WB→ID forwarding is needed.
- All outputs are combinational from stage registers only; there is no input-to-output path.
- Stall holds the outputs stable, so the register file rewrites the same value each stalled cycle. This is harmless and required.
- Flush and stall together resolve as flush.
- Reset asserted mid-operation clears valid immediately and asynchronously. wrEnable drops before the next falling edge, so no write occurs.

## Structure
- A shared package `mips_pkg` holds:
  - the WB_ALU/WB_LOAD/WB_LINK encodings;
  - the LD_W/LD_B/LD_BU/LD_H/LD_HU encodings;
  - the REG_ZERO constant.
- One combinational sub-module, `load_formatter`, takes loadType, offset and memData and returns data and misalign. The sub-module is reused by a future cache path.

## Test plan
- Reset: rstN=0 then 1 → all outputs 0 and retireCount=0. Assert rstN=0 mid-stream with valid=1 → wrEnable falls within the same cycle.
- ALU writeback: valid, regWrite, wbSel=00, dest=8, alu=0x1234 → next cycle wrEnable=1, wrReg=8, wrData=0x1234. A read of register 8 after that cycle's falling edge returns 0x1234.
- Loads with memData=0x80FF7F01:
  - LB off0 → 0xFFFFFF80;
  - LBU off1 → 0x000000FF;
  - LH off2 → 0x00007F01;
  - LHU off0 → 0x000080FF;
  - LW off2 → misalignErr=1, wrEnable=0.
- Link and $zero:
  - wbSel=10, pc=0xFFFFFFFC → wrData=0x00000004.
  - dest=0 with regWrite=1 → wrEnable=0.
- Stall/flush: capture instruction A, then stall 3 cycles → outputs hold A and retireCount rises by 1 only. Assert flush and stall together → wrEnable=0 next cycle.
- Counter wrap: preload retireCount=0xFFFFFFFF (or run long) → one valid retire gives 0.
